mem_port_arbiter: RTL and testbench

- Shares one synchronous single-port data SRAM between N requesters, for example the CPU data port, a loader or debug port, and a DMA engine.
- Round-robin arbitration. At most one access per cycle reaches the SRAM.
- Grant is combinational in the request cycle. Read data returns with fixed 1-cycle latency and is routed back to the requester that issued the read.
- Sits between requesters and the SRAM, which uses byte write strobes and word addressing on byte addresses.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among N requesters.
// Define MEM_PORT_ARBITER_LOCK_EN to build the bus-lock FSM.
module mem_port_arbiter #(
    parameter int N    = 3,
    parameter int AW   = 32,
    parameter int PTRW = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N-1:0]    lock,
    input  logic [N*AW-1:0] addr,
    input  logic [N*32-1:0] wdata,
    input  logic [N*4-1:0]  wstrb,
    output logic [N-1:0]    gnt,
    output logic [N-1:0]    rvalid,
    output logic [31:0]     rdata,
    output logic            m_en,
    output logic [AW-1:0]   m_addr,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    input  logic [31:0]     m_rdata
);

    logic [PTRW-1:0] rr_ptr;
    logic [PTRW-1:0] rr_ptr_next;
    logic [PTRW-1:0] sel;
    logic [N-1:0]    elig;
    logic [N-1:0]    rv_q;
    logic            hit;

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (int'(p) == N - 1) ? '0 : p + 1'b1;
    endfunction

`ifdef MEM_PORT_ARBITER_LOCK_EN
    typedef enum logic {IDLE, LOCKED} state_t;

    state_t          state;
    state_t          state_next;
    logic [PTRW-1:0] owner;
    logic [PTRW-1:0] owner_next;
    logic            lock_sel;
    logic            lock_own;

    // While locked, only the owner may compete for the port.
    always_comb begin
        elig     = req;
        lock_sel = 1'b0;
        lock_own = 1'b0;
        if (state == LOCKED) begin
            elig = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (state == LOCKED && owner == PTRW'(i)) begin
                elig[i] = req[i];
            end
            if (sel == PTRW'(i)) begin
                lock_sel = lock[i];
            end
            if (owner == PTRW'(i)) begin
                lock_own = lock[i];
            end
        end
    end

    always_comb begin
        state_next  = state;
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    rr_ptr_next = ptr_inc(sel);
                    if (lock_sel) begin
                        state_next = LOCKED;
                        owner_next = sel;
                    end
                end
            end
            LOCKED: begin
                if (!hit || !lock_own) begin
                    state_next  = IDLE;
                    rr_ptr_next = ptr_inc(owner);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
        end else begin
            state <= state_next;
            owner <= owner_next;
        end
    end
`else
    logic unused_lock;

    assign unused_lock = ^lock;
    assign elig        = req;

    always_comb begin
        rr_ptr_next = rr_ptr;
        if (hit) begin
            rr_ptr_next = ptr_inc(sel);
        end
    end
`endif

    // First eligible index at or after rr_ptr, wrapping modulo N.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!hit && elig[i] && i == (int'(rr_ptr) + k) % N) begin
                    hit = 1'b1;
                    sel = PTRW'(i);
                end
            end
        end
    end

    always_comb begin
        gnt     = '0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        for (int i = 0; i < N; i++) begin
            if (hit && !reset && sel == PTRW'(i)) begin
                gnt[i]  = 1'b1;
                m_addr  = addr[i*AW +: AW];
                m_wdata = wdata[i*32 +: 32];
                m_wstrb = wstrb[i*4 +: 4];
            end
        end
    end

    assign m_en = |gnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= '0;
            rv_q   <= '0;
        end else begin
            rr_ptr <= rr_ptr_next;
            rv_q   <= (m_wstrb == 4'd0) ? gnt : '0;
        end
    end

    // A read in flight when reset rises is dropped in that same cycle.
    assign rvalid = rv_q & {N{~reset}};
    assign rdata  = m_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter against a reference model.
// Expectations follow MEM_PORT_ARBITER_LOCK_EN when it is defined.
module tb_mem_port_arbiter;

    localparam int N = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req_v;
    logic [2:0]  lock_v;
    logic [31:0] a_v [3];
    logic [31:0] d_v [3];
    logic [3:0]  s_v [3];
    logic [95:0] addr;
    logic [95:0] wdata;
    logic [11:0] wstrb;
    logic [2:0]  gnt;
    logic [2:0]  rvalid;
    logic [31:0] rdata;
    logic        m_en;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic [31:0] m_rdata;
    logic [31:0] sram [16];

    int          checks = 0;
    int          failures = 0;

    int          ptr;
    int          owner;
    bit          locked;
    logic [2:0]  pend_rv;
    logic [31:0] pend_data;
    logic [31:0] ref_mem [16];
    logic [2:0]  obs_gnt;
    logic [2:0]  obs_rv;
    logic [31:0] obs_rdata;
    logic [3:0]  obs_wstrb;
    int          last_g;

    assign addr  = {a_v[2], a_v[1], a_v[0]};
    assign wdata = {d_v[2], d_v[1], d_v[0]};
    assign wstrb = {s_v[2], s_v[1], s_v[0]};

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(3), .AW(32), .PTRW(3)) dut (
        .clk(clk), .reset(reset), .req(req_v), .lock(lock_v),
        .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_rdata(m_rdata)
    );

    always @(posedge clk) begin
        if (m_en) begin
            if (m_wstrb == 4'd0) begin
                m_rdata <= sram[m_addr[5:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (m_wstrb[b]) sram[m_addr[5:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick();
        if (locked) return req_v[owner] ? owner : -1;
        for (int k = 0; k < N; k++) begin
            if (req_v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic tick(input logic rst);
        int         g;
        logic [2:0] eg;
        reset = rst;
        @(negedge clk);
        g  = rst ? -1 : pick();
        eg = (g >= 0) ? 3'(1 << g) : 3'd0;
        check("gnt", 32'(gnt), 32'(eg));
        check("m_en", 32'(m_en), 32'(g >= 0));
        check("rvalid", 32'(rvalid), rst ? 32'd0 : 32'(pend_rv));
        if (g >= 0) begin
            check("m_addr", m_addr, a_v[g]);
            check("m_wdata", m_wdata, d_v[g]);
            check("m_wstrb", 32'(m_wstrb), 32'(s_v[g]));
        end else begin
            check("m_wstrb_idle", 32'(m_wstrb), 32'd0);
        end
        if (!rst && pend_rv != 3'd0) check("rdata", rdata, pend_data);
        obs_gnt   = gnt;
        obs_rv    = rvalid;
        obs_rdata = rdata;
        obs_wstrb = m_wstrb;
        if (rst) begin
            ptr = 0; locked = 0; owner = 0; pend_rv = '0;
        end else begin
            pend_rv = '0;
            if (g >= 0) begin
                if (s_v[g] == 4'd0) begin
                    pend_rv   = eg;
                    pend_data = ref_mem[a_v[g][5:2]];
                end else begin
                    for (int b = 0; b < 4; b++) begin
                        if (s_v[g][b]) ref_mem[a_v[g][5:2]][b*8 +: 8] = d_v[g][b*8 +: 8];
                    end
                end
            end
`ifdef MEM_PORT_ARBITER_LOCK_EN
            if (!locked) begin
                if (g >= 0) begin
                    ptr = (g + 1) % N;
                    if (lock_v[g]) begin locked = 1; owner = g; end
                end
            end else if (g < 0 || !lock_v[owner]) begin
                locked = 0;
                ptr = (owner + 1) % N;
            end
`else
            if (g >= 0) ptr = (g + 1) % N;
`endif
        end
        last_g = g;
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int i, input logic [31:0] a);
        req_v[i] = 1'b1; a_v[i] = a; s_v[i] = 4'd0; d_v[i] = $urandom;
    endtask

    logic [2:0] rr_exp [4];
    logic [2:0] lk_exp [4];
    logic [2:0] prev;

    initial begin
        for (int w = 0; w < 16; w++) begin
            sram[w] = $urandom;
            ref_mem[w] = sram[w];
        end
        m_rdata = '0;
        req_v = '0; lock_v = '0; pend_rv = '0; pend_data = '0;
        ptr = 0; owner = 0; locked = 0; last_g = -1;
        for (int i = 0; i < 3; i++) begin
            a_v[i] = '0; d_v[i] = '0; s_v[i] = '0;
        end
        tick(1'b1);
        tick(1'b1);

        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};
        set_rd(0, 32'h0); set_rd(1, 32'h4); set_rd(2, 32'h8);
        prev = '0;
        for (int k = 0; k < 4; k++) begin
            tick(1'b0);
            check("rr_seq", 32'(obs_gnt), 32'(rr_exp[k]));
            check("rv_follow", 32'(obs_rv), 32'(prev));
            prev = obs_gnt;
        end

        tick(1'b1);
        req_v = 3'b001; a_v[0] = 32'h10; d_v[0] = 32'hDEADBEEF; s_v[0] = 4'b0011;
        tick(1'b0);
        check("wr_strb", 32'(obs_wstrb), 32'h3);
        req_v = '0; set_rd(1, 32'h10);
        tick(1'b0);
        check("wr_no_rv", 32'(obs_rv), 32'd0);
        req_v = '0;
        tick(1'b0);
        check("rd_rv", 32'(obs_rv), 32'h2);
        check("rd_half", 32'(obs_rdata[15:0]), 32'hBEEF);

        tick(1'b1);
        req_v = '0; set_rd(0, 32'h20); set_rd(1, 32'h24);
        tick(1'b0);
        req_v[0] = 1'b0;
        tick(1'b0);
        req_v = '0; set_rd(0, 32'h28); set_rd(2, 32'h2C);
        tick(1'b0);
        check("wrap_hi", 32'(obs_gnt), 32'h4);
        tick(1'b0);
        check("wrap_lo", 32'(obs_gnt), 32'h1);

        tick(1'b1);
        req_v = '0; set_rd(1, 32'h30);
        tick(1'b0);
        check("mid_gnt", 32'(obs_gnt), 32'h2);
        set_rd(0, 32'h34); set_rd(2, 32'h38);
        tick(1'b1);
        check("mid_rv_t1", 32'(obs_rv), 32'd0);
        tick(1'b0);
        check("mid_rv_t2", 32'(obs_rv), 32'd0);
        check("mid_gnt_after", 32'(obs_gnt), 32'h1);

`ifdef MEM_PORT_ARBITER_LOCK_EN
        lk_exp = '{3'b100, 3'b100, 3'b100, 3'b001};
`else
        lk_exp = '{3'b100, 3'b001, 3'b010, 3'b100};
`endif
        tick(1'b1);
        set_rd(0, 32'h0); set_rd(1, 32'h4); set_rd(2, 32'h8); lock_v = '0;
        tick(1'b0);
        tick(1'b0);
        lock_v = 3'b100;
        tick(1'b0);
        check("lock_g0", 32'(obs_gnt), 32'(lk_exp[0]));
        tick(1'b0);
        check("lock_g1", 32'(obs_gnt), 32'(lk_exp[1]));
        lock_v = 3'b000;
        tick(1'b0);
        check("lock_g2", 32'(obs_gnt), 32'(lk_exp[2]));
        tick(1'b0);
        check("lock_g3", 32'(obs_gnt), 32'(lk_exp[3]));

        tick(1'b1);
        req_v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (last_g == i || !req_v[i]) begin
                    req_v[i] = ($urandom_range(0, 2) != 0);
                    a_v[i]   = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    d_v[i]   = $urandom;
                    s_v[i]   = ($urandom_range(0, 1) != 0) ?
                               4'($urandom_range(1, 15)) : 4'd0;
                end
                lock_v[i] = ($urandom_range(0, 3) == 0);
            end
            tick($urandom_range(0, 49) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
